// File: rtl/aiv_timing_pkg.sv
// AIV raster timing constants shared by the transmit generator and receive trackers.
// 625-line interlaced PAL at 13.5 MHz dot rate from an 81 MHz system clock.
package aiv_timing_pkg;

    localparam int CLK_DIV          = 6;
    localparam int H_TOTAL          = 864;
    localparam int H_ACTIVE_START   = 72;
    localparam int H_ACTIVE         = 720;
    localparam int V_ACTIVE_START   = 23;
    localparam int V_ACTIVE         = 288;
    localparam int ODD_FIELD_LINES  = 313;
    localparam int EVEN_FIELD_LINES = 312;

    localparam int DIV_W = 8;

    typedef logic [9:0]       coord_t;
    typedef logic [DIV_W-1:0] div_t;

    function automatic coord_t last_line(input logic odd);
        return odd ? coord_t'(ODD_FIELD_LINES - 1)
                   : coord_t'(EVEN_FIELD_LINES - 1);
    endfunction

endpackage

// File: rtl/aiv_raster_counter.sv
// clk_div/dot/line/field raster counters with run gating and optional genlock load.
// AIV_SYNC_GENLOCK_EN adds extVsync, which restarts the raster at line 0 of the odd field.
module aiv_raster_counter #(
    parameter int CLK_DIV = aiv_timing_pkg::CLK_DIV,
    parameter int H_TOTAL = aiv_timing_pkg::H_TOTAL
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       run,
`ifdef AIV_SYNC_GENLOCK_EN
    input  logic       extVsync,
`endif
    output logic [7:0] clk_div_o,
    output logic [9:0] dot_o,
    output logic [9:0] line_o,
    output logic       odd_o
);
    import aiv_timing_pkg::*;

    div_t   clk_div_q, clk_div_d;
    coord_t dot_q, dot_d;
    coord_t line_q, line_d;
    logic   odd_q, odd_d;

    logic div_wrap, dot_wrap, line_wrap, load;

    assign div_wrap  = (clk_div_q == div_t'(CLK_DIV - 1));
    assign dot_wrap  = div_wrap && (dot_q == coord_t'(H_TOTAL - 1));
    assign line_wrap = dot_wrap && (line_q == last_line(odd_q));

`ifdef AIV_SYNC_GENLOCK_EN
    logic [2:0] sync_q;
    logic       edge_q;

    always_ff @(posedge clk) begin
        if (!nReset || !run) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], extVsync};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    // Already at the frame origin: let the raster run on undisturbed.
    assign load = edge_q && !(line_q == '0 && dot_q == '0 && odd_q);
`else
    assign load = 1'b0;
`endif

    always_comb begin
        clk_div_d = div_wrap ? '0 : clk_div_q + 1'b1;
        dot_d     = dot_q;
        line_d    = line_q;
        odd_d     = odd_q;
        if (div_wrap) begin
            dot_d = dot_wrap ? '0 : dot_q + 1'b1;
        end
        if (dot_wrap) begin
            line_d = line_wrap ? '0 : line_q + 1'b1;
        end
        if (line_wrap) begin
            odd_d = ~odd_q;
        end
        if (load) begin
            clk_div_d = '0;
            dot_d     = '0;
            line_d    = '0;
            odd_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nReset || !run) begin
            clk_div_q <= '0;
            dot_q     <= '0;
            line_q    <= '0;
            odd_q     <= 1'b1;
        end else begin
            clk_div_q <= clk_div_d;
            dot_q     <= dot_d;
            line_q    <= line_d;
            odd_q     <= odd_d;
        end
    end

    assign clk_div_o = clk_div_q;
    assign dot_o     = dot_q;
    assign line_o    = line_q;
    assign odd_o     = odd_q;

endmodule

// File: rtl/aiv_sync_generator.sv
// Transmit-side AIV sync generator: registered hsync/vsync/field/active-region decode.
// Define AIV_SYNC_GENLOCK_EN to add the extVsync genlock input.
module aiv_sync_generator #(
    parameter int CLK_DIV        = aiv_timing_pkg::CLK_DIV,
    parameter int H_TOTAL        = aiv_timing_pkg::H_TOTAL,
    parameter int H_ACTIVE_START = aiv_timing_pkg::H_ACTIVE_START,
    parameter int H_ACTIVE       = aiv_timing_pkg::H_ACTIVE,
    parameter int V_ACTIVE_START = aiv_timing_pkg::V_ACTIVE_START,
    parameter int V_ACTIVE       = aiv_timing_pkg::V_ACTIVE,
    parameter int HSYNC_WIDTH    = 1,
    parameter int VSYNC_WIDTH    = 1
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       run,
`ifdef AIV_SYNC_GENLOCK_EN
    input  logic       extVsync,
`endif
    output logic       hsync,
    output logic       vsync,
    output logic       isFieldOdd,
    output logic       dot_strobe,
    output logic [9:0] active_frame_dot,
    output logic [9:0] active_frame_line,
    output logic       display_enable,
    output logic       frame_start_flag
);
    import aiv_timing_pkg::*;

    div_t   clk_div;
    coord_t dot, line, line_off;
    logic   odd, h_act, v_act, act, origin;

    aiv_raster_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL)
    ) u_cnt (
        .clk       (clk),
        .nReset    (nReset),
        .run       (run),
`ifdef AIV_SYNC_GENLOCK_EN
        .extVsync  (extVsync),
`endif
        .clk_div_o (clk_div),
        .dot_o     (dot),
        .line_o    (line),
        .odd_o     (odd)
    );

    assign h_act = (dot >= coord_t'(H_ACTIVE_START))
                && (dot < coord_t'(H_ACTIVE_START + H_ACTIVE));
    assign v_act = (line >= coord_t'(V_ACTIVE_START))
                && (line < coord_t'(V_ACTIVE_START + V_ACTIVE));
    assign act      = h_act && v_act;
    assign line_off = line - coord_t'(V_ACTIVE_START);
    assign origin   = (dot == '0);

    logic   hsync_q, vsync_q, odd_q, strobe_q, de_q, fsf_q;
    coord_t afd_q, afl_q;

    always_ff @(posedge clk) begin
        if (!nReset || !run) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            odd_q    <= 1'b1;
            strobe_q <= 1'b0;
            de_q     <= 1'b0;
            fsf_q    <= 1'b0;
            afd_q    <= '0;
            afl_q    <= '0;
        end else begin
            hsync_q  <= origin && (clk_div < div_t'(HSYNC_WIDTH));
            vsync_q  <= origin && (line == '0)
                     && (clk_div < div_t'(VSYNC_WIDTH));
            odd_q    <= odd;
            strobe_q <= (clk_div == '0);
            de_q     <= act;
            fsf_q    <= odd && (clk_div == '0)
                     && (line == coord_t'(V_ACTIVE_START))
                     && (dot == coord_t'(H_ACTIVE_START));
            afd_q    <= act ? dot - coord_t'(H_ACTIVE_START) : '0;
            afl_q    <= act ? (line_off << 1) | coord_t'(odd) : '0;
        end
    end

    assign hsync             = hsync_q;
    assign vsync             = vsync_q;
    assign isFieldOdd        = odd_q;
    assign dot_strobe        = strobe_q;
    assign display_enable    = de_q;
    assign frame_start_flag  = fsf_q;
    assign active_frame_dot  = afd_q;
    assign active_frame_line = afl_q;

endmodule

// File: tb/tb_aiv_sync_generator.sv
// Bench for aiv_sync_generator with a shortened line so whole frames fit the run.
// Arithmetic reference model feeds a scoreboard; directed points use fixed constants.
`timescale 1ns/1ps
module tb_aiv_sync_generator;

    localparam int D   = 3;
    localparam int H   = 12;
    localparam int HS  = 2;
    localparam int HA  = 8;
    localparam int VS  = 23;
    localparam int VA  = 288;
    localparam int HSW = 2;
    localparam int VSW = 1;

    localparam int LINE    = H * D;
    localparam int ODDLEN  = 313 * LINE;
    localparam int EVENLEN = 312 * LINE;
    localparam int FRAME   = ODDLEN + EVENLEN;
    localparam int DE0     = VS * LINE + HS * D;
    localparam logic [25:0] RST_VEC = 26'h0800000;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic run = 1'b0;
    logic extVsync = 1'b0;
    logic hsync, vsync, isFieldOdd, dot_strobe;
    logic display_enable, frame_start_flag;
    logic [9:0] active_frame_dot, active_frame_line;
    logic [25:0] obs;

    aiv_sync_generator #(
        .CLK_DIV        (D),
        .H_TOTAL        (H),
        .H_ACTIVE_START (HS),
        .H_ACTIVE       (HA),
        .V_ACTIVE_START (VS),
        .V_ACTIVE       (VA),
        .HSYNC_WIDTH    (HSW),
        .VSYNC_WIDTH    (VSW)
    ) dut (
        .clk               (clk),
        .nReset            (nReset),
        .run               (run),
`ifdef AIV_SYNC_GENLOCK_EN
        .extVsync          (extVsync),
`endif
        .hsync             (hsync),
        .vsync             (vsync),
        .isFieldOdd        (isFieldOdd),
        .dot_strobe        (dot_strobe),
        .active_frame_dot  (active_frame_dot),
        .active_frame_line (active_frame_line),
        .display_enable    (display_enable),
        .frame_start_flag  (frame_start_flag)
    );

    always #5 clk = ~clk;

    assign obs = {hsync, vsync, isFieldOdd, dot_strobe, display_enable,
                  frame_start_flag, active_frame_dot, active_frame_line};

    int checks = 0;
    int failures = 0;
    logic [25:0] sb_q[$];
    int n = 0;
    int pos = 0;
    int cyc = 0;
    bit live = 1'b0;
    bit cmp_en = 1'b1;
    int vs_t[$];
    bit vs_odd[$];
    int hs_t[$];
    int ds_t[$];
    logic prev_vs = 1'b0;
    logic prev_hs = 1'b0;
    int hs_len = 0;
    int hs_w0 = -1;
    int de_cnt = 0;
    int fs_cnt = 0;

    function automatic logic [25:0] model(input bit rst_n, input bit rn, input int s);
        int p, q, ln, r, dt, cd, afd, afl;
        bit odd, act;
        if (!rst_n || !rn) return RST_VEC;
        p   = s % FRAME;
        odd = (p < ODDLEN);
        q   = odd ? p : p - ODDLEN;
        ln  = q / LINE;
        r   = q % LINE;
        dt  = r / D;
        cd  = r % D;
        act = (dt >= HS) && (dt < HS + HA) && (ln >= VS) && (ln < VS + VA);
        afd = act ? dt - HS : 0;
        afl = act ? 2 * (ln - VS) + int'(odd) : 0;
        return {(dt == 0 && cd < HSW), (ln == 0 && dt == 0 && cd < VSW), odd,
                (cd == 0), act, (odd && ln == VS && dt == HS && cd == 0),
                10'(afd), 10'(afl)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    task automatic points();
        if (pos == 0) begin
            chk("start_hsync", 32'(hsync), 32'd1);
            chk("start_vsync", 32'(vsync), 32'd1);
            chk("start_odd", 32'(isFieldOdd), 32'd1);
        end
        if (pos == DE0) begin
            chk("de_rise", 32'(display_enable), 32'd1);
            chk("de_rise_line", 32'(active_frame_line), 32'd1);
            chk("de_rise_dot", 32'(active_frame_dot), 32'd0);
            chk("fsf_high", 32'(frame_start_flag), 32'd1);
        end
        if (pos == DE0 + 1) chk("fsf_one_clk", 32'(frame_start_flag), 32'd0);
        if (pos == VS * LINE + (HS + HA - 1) * D)
            chk("last_dot", 32'(active_frame_dot), 32'd7);
        if (pos == VS * LINE + (HS + HA) * D)
            chk("de_fall", 32'(display_enable), 32'd0);
        if (pos == ODDLEN + 310 * LINE + 5 * D) begin
            chk("even_line", 32'(active_frame_line), 32'd574);
            chk("even_dot", 32'(active_frame_dot), 32'd3);
            chk("even_field", 32'(isFieldOdd), 32'd0);
        end
        if (pos == ODDLEN + 311 * LINE + 5 * D)
            chk("even_311_off", 32'(display_enable), 32'd0);
    endtask

    task automatic step();
        logic [25:0] e;
        pos  = n;
        live = nReset && run;
        sb_q.push_back(model(nReset, run, n));
        @(posedge clk);
        n = live ? n + 1 : 0;
        #1;
        e = sb_q.pop_front();
        if (cmp_en) chk("cycle", 32'(obs), 32'(e));
        if (live) points();
        if (vsync && !prev_vs) begin
            vs_t.push_back(cyc);
            vs_odd.push_back(isFieldOdd);
        end
        if (hsync && !prev_hs && hs_t.size() < 2) hs_t.push_back(cyc);
        prev_vs = vsync;
        prev_hs = hsync;
        if (hsync) hs_len++;
        else begin
            if (hs_len > 0 && hs_w0 < 0) hs_w0 = hs_len;
            hs_len = 0;
        end
        if (dot_strobe && ds_t.size() < 3) ds_t.push_back(cyc);
        if (live && dot_strobe && display_enable && pos < 2 * FRAME) de_cnt++;
        if (live && frame_start_flag && pos < 2 * FRAME) fs_cnt++;
        cyc++;
    endtask

    initial begin
        repeat (3) step();
        chk("reset_vec", 32'(obs), 32'(RST_VEC));
        nReset = 1'b1;
        repeat (2) step();
        chk("idle_vec", 32'(obs), 32'(RST_VEC));

        run = 1'b1;
        repeat (2 * FRAME + 10) step();

        chk("vsync_count", 32'(vs_t.size() >= 5), 32'd1);
        if (vs_t.size() >= 5) begin
            chk("odd_period", 32'(vs_t[1] - vs_t[0]), 32'(ODDLEN));
            chk("even_period", 32'(vs_t[2] - vs_t[1]), 32'(EVENLEN));
            chk("odd_period2", 32'(vs_t[3] - vs_t[2]), 32'(ODDLEN));
            chk("even_period2", 32'(vs_t[4] - vs_t[3]), 32'(EVENLEN));
            chk("field_seq", 32'({vs_odd[0], vs_odd[1], vs_odd[2], vs_odd[3], vs_odd[4]}),
                32'b10101);
        end
        chk("hsync_count", 32'(hs_t.size()), 32'd2);
        if (hs_t.size() == 2) chk("hsync_period", 32'(hs_t[1] - hs_t[0]), 32'(LINE));
        chk("hsync_width", 32'(hs_w0), 32'(HSW));
        chk("strobe_count", 32'(ds_t.size()), 32'd3);
        if (ds_t.size() == 3) begin
            chk("strobe_period", 32'(ds_t[1] - ds_t[0]), 32'(D));
            chk("strobe_period2", 32'(ds_t[2] - ds_t[1]), 32'(D));
        end
        chk("de_strobes", 32'(de_cnt), 32'(2 * 2 * VA * HA));
        chk("fsf_count", 32'(fs_cnt), 32'd2);

        while (n < 2 * FRAME + 150 * LINE + 7) step();
        chk("pre_reset_odd", 32'(isFieldOdd), 32'd1);
        nReset = 1'b0;
        step();
        chk("mid_reset", 32'(obs), 32'(RST_VEC));
        nReset = 1'b1;
        repeat (200) step();

        run = 1'b0;
        step();
        chk("run_low", 32'(obs), 32'(RST_VEC));
        repeat (2) step();
        run = 1'b1;
        repeat (100) step();

`ifdef AIV_SYNC_GENLOCK_EN
        begin
            int found_i;
            while (n < ODDLEN + 200 * LINE) step();
            cmp_en = 1'b0;
            extVsync = 1'b1;
            found_i = -1;
            for (int i = 0; i < 8 && found_i < 0; i++) begin
                step();
                if (vsync) found_i = i;
            end
            chk("gl_seen", 32'(found_i >= 0 && found_i <= 4), 32'd1);
            chk("gl_odd", 32'(isFieldOdd), 32'd1);
            chk("gl_hsync", 32'(hsync), 32'd1);
            extVsync = 1'b0;
            n = 1;
            cmp_en = 1'b1;
            repeat (3 * LINE) step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aiv_sync_generator.md
Name: aiv_sync_generator

Overview:
- Transmit-side AIV raster timing source, for frames the FPGA originates (AIV overlay/test output).
- Generates 625-line interlaced PAL timing at 13.5 MHz dot rate, derived from the 81 MHz system clock.
- Outputs hsync, vsync, field parity and active-frame dot/line/display-enable, using the same conventions as the AIV input path.
- Downstream pixel sources and the video encoder consume these signals directly.

Parameters:
- CLK_DIV, 6: system clocks per dot (81 MHz / 6 = 13.5 MHz).
- H_TOTAL, 864: dots per line.
- H_ACTIVE_START, 72: first active dot.
- H_ACTIVE, 720: active dots per line.
- V_ACTIVE_START, 23: first active field line.
- V_ACTIVE, 288: active lines per field.
- HSYNC_WIDTH, 1: hsync pulse width in clk cycles, range 1..CLK_DIV.
- VSYNC_WIDTH, 1: vsync pulse width in clk cycles, range 1..CLK_DIV.

Ports:
- clk  in  1  81 MHz system clock.
- nReset  in  1  reset.
- run  in  1  1 = generate timing; 0 = hold at start position.
- hsync  out  1  line-start pulse.
- vsync  out  1  field-start pulse.
- isFieldOdd  out  1  1 = odd field (313 lines), 0 = even field (312 lines).
- dot_strobe  out  1  one-clk pulse per dot period.
- active_frame_dot  out  10  0..719, 0 outside the active region.
- active_frame_line  out  10  0..575 interleaved frame line, 0 outside the active region.
- display_enable  out  1  active region flag.
- frame_start_flag  out  1  one-clk pulse at the first active pixel of the frame.

Interface: one clock; reset is synchronous and active-low (clk, nReset). nReset is sampled only on posedge clk.

Behaviour:
- Reset state (nReset=0 at posedge):
  - Internal: clk_div=0, dot=0, line=0, field=odd.
  - Outputs: hsync=0, vsync=0, isFieldOdd=1, dot_strobe=0, display_enable=0, active_frame_dot=0, active_frame_line=0, frame_start_flag=0.
- Reset mid-frame: all outputs take reset values on the next clk edge. No partial-line completion.
- run=0: counters and outputs forced to reset values every cycle; reset has priority over run.
- First clk with run=1: counters begin at dot 0, line 0, odd field.
- Counters (advance only while run=1):
  - clk_div counts 0..CLK_DIV-1 and wraps.
  - dot increments when clk_div wraps; dot wraps H_TOTAL-1 -> 0.
  - line increments on dot wrap.
  - Line wrap point: 312 -> 0 in the odd field, 311 -> 0 in the even field.
  - field toggles on line wrap, giving 625 lines per frame.
- Output latency: all outputs are registered decodes of the current counters, valid 1 clk after the counter state. No combinational paths from inputs to outputs.
- dot_strobe: decode clk_div==0.
- hsync: decode dot==0 and clk_div<HSYNC_WIDTH.
- vsync: decode line==0, dot==0 and clk_div<VSYNC_WIDTH. vsync is coincident with hsync on line 0.
- isFieldOdd: registered field bit. It changes in the same cycle vsync rises.
- Active region:
  - Condition: H_ACTIVE_START <= dot < H_ACTIVE_START+H_ACTIVE and V_ACTIVE_START <= line < V_ACTIVE_START+V_ACTIVE.
  - Inside: display_enable=1, active_frame_dot=dot-H_ACTIVE_START, active_frame_line=2*(line-V_ACTIVE_START)+(odd?1:0).
  - Outside: all three are 0.
  - Held constant across all CLK_DIV clocks of a dot.
  - Line 311 (even) and lines 311..312 (odd) are inactive.
- frame_start_flag: decode odd field, line==V_ACTIVE_START, dot==H_ACTIVE_START, clk_div==0. Exactly one clk per frame.
- Arithmetic: 10-bit unsigned throughout; the line*2 product fits (max 575).

Optional Feature:
- Macro: AIV_SYNC_GENLOCK_EN.
- Defined:
  - Adds input extVsync (1 bit).
  - A rising edge is detected with a 2-flop synchroniser plus edge register.
  - On the edge, counters load clk_div=0, dot=0, line=0, field=odd on the next clk. vsync/hsync follow with normal 1-clk latency.
  - An edge arriving while already at line 0/dot 0 of the odd field causes no disturbance.
  - run=0 ignores extVsync.
- Undefined: port absent; free-running timing only.

Decomposition:
- Package aiv_timing_pkg: constants for H_TOTAL, H_ACTIVE_START, H_ACTIVE, V_ACTIVE_START, V_ACTIVE, ODD_FIELD_LINES=313, EVEN_FIELD_LINES=312, CLK_DIV. Shared with the AIV receive-side trackers.
- Sub-module aiv_raster_counter: clk_div/dot/line/field counters with run, wrap and genlock-load control.
- Top level: registered output decode only.

Test Plan:
- Reset, then run=1 at clk T → hsync=vsync=1 and isFieldOdd=1 at T+1; next hsync at T+1+5184; hsync width 1 clk; dot_strobe every 6 clks.
- Free run 2 frames → vsync intervals alternate 1,622,592 (odd) and 1,617,408 (even) clks; isFieldOdd toggles at each vsync.
- Odd field, line 23, dot 72 → display_enable rises with active_frame_line=1, active_frame_dot=0; frame_start_flag high 1 clk; dot 791 gives active_frame_dot=719, dot 792 gives display_enable=0; 414,720 DE-qualified dot_strobes per frame.
- Even field, line 310, dot 100 → active_frame_line=574, active_frame_dot=28; line 311 → display_enable=0.
- nReset=0 at odd line 150 → next clk all outputs at reset values; release with run=1 → timing restarts from line 0 odd.
- AIV_SYNC_GENLOCK_EN: extVsync rising edge during even line 200 → counters at line 0 odd within 4 clks; vsync and hsync pulse 1 clk later; period from that point is unchanged.
